// File: rtl/mem_req_queue_if.sv
// mem_req_queue_if: request-in and head-out handshakes of mem_req_queue.
// master drives requests and out_ready; slave is the queue.
interface mem_req_queue_if #(
    parameter int ADDR_W = 33,
    parameter int OP_W   = 2,
    parameter int TS_W   = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [ADDR_W-1:0] in_addr;
    logic [TS_W-1:0]   in_time;
    logic              out_valid;
    logic              out_ready;
    logic [OP_W-1:0]   out_op;
    logic [ADDR_W-1:0] out_addr;
    logic [TS_W-1:0]   out_time;

    modport master (
        output in_valid, in_op, in_addr, in_time, out_ready,
        input  in_ready, out_valid, out_op, out_addr, out_time
    );

    modport slave (
        input  in_valid, in_op, in_addr, in_time, out_ready,
        output in_ready, out_valid, out_op, out_addr, out_time
    );
endinterface

// File: rtl/mem_req_queue.sv
// mem_req_queue: timestamp-gated circular request queue for the DRAM scheduler.
// Define MEM_REQ_QUEUE_AGE_EXPIRE_EN to build head-entry aging and expiry.
module mem_req_queue #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 33,
    parameter int OP_W     = 2,
    parameter int TS_W     = 32,
    parameter int LIFE_MAX = 100
) (
    input  logic                       CPU_clock,
    input  logic                       rst_n,
    mem_req_queue_if.slave             bus,
    output logic [TS_W-1:0]            cur_time,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       insert_flag,
    output logic                       expire_flag
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;

    logic [OP_W-1:0]   op_q   [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [TS_W-1:0]   time_q [DEPTH];

    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TS_W-1:0]  cur_time_q, cur_time_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             insert_q, insert_d;
    logic             expire_q, expire_d;

    logic in_ready;
    logic out_valid;
    logic push;
    logic pop;
    logic expire;
    logic remove;
    logic advance;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign in_ready      = rst_n && !full_q;
    assign out_valid     = rst_n && !empty_q;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_op    = op_q[rd_ptr_q];
    assign bus.out_addr  = addr_q[rd_ptr_q];
    assign bus.out_time  = time_q[rd_ptr_q];

    assign cur_time    = cur_time_q;
    assign count       = count_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign insert_flag = insert_q;
    assign expire_flag = expire_q;

`ifdef MEM_REQ_QUEUE_AGE_EXPIRE_EN
    localparam int AGE_W = $clog2(LIFE_MAX + 1);

    logic [AGE_W-1:0] age_q [DEPTH];
    logic [AGE_W-1:0] age_d [DEPTH];

    // Head retires on the edge whose increment would bring it to LIFE_MAX.
    assign expire = out_valid && !bus.out_ready &&
                    (age_q[rd_ptr_q] >= AGE_W'(LIFE_MAX - 1));

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = age_q[i];
            if (age_q[i] != AGE_W'(LIFE_MAX)) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end
            if (push && (wr_ptr_q == ptr_t'(i))) begin
                age_d[i] = '0;
            end
        end
    end

    always_ff @(posedge CPU_clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst_n) begin
                age_q[i] <= '0;
            end else begin
                age_q[i] <= age_d[i];
            end
        end
    end
`else
    logic unused_life;

    assign expire      = 1'b0;
    assign unused_life = ^LIFE_MAX;
`endif

    always_comb begin
        advance = empty_q && bus.in_valid && in_ready &&
                  (bus.in_time > cur_time_q);
        push    = bus.in_valid && in_ready &&
                  ((bus.in_time <= cur_time_q) || empty_q);
        pop     = out_valid && bus.out_ready;
        remove  = pop || expire;

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = remove ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        unique case ({push, remove})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d     = (count_d == CNT_W'(DEPTH));
        empty_d    = (count_d == '0);
        cur_time_d = advance ? bus.in_time : cur_time_q + TS_W'(1);
        insert_d   = push;
        expire_d   = expire;
    end

    always_ff @(posedge CPU_clock) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cur_time_q <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            insert_q   <= 1'b0;
            expire_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cur_time_q <= cur_time_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            insert_q   <= insert_d;
            expire_q   <= expire_d;
        end
    end

    always_ff @(posedge CPU_clock) begin
        if (push) begin
            op_q[wr_ptr_q]   <= bus.in_op;
            addr_q[wr_ptr_q] <= bus.in_addr;
            time_q[wr_ptr_q] <= bus.in_time;
        end
    end
endmodule

// File: tb/tb_mem_req_queue.sv
// tb_mem_req_queue: random and directed stimulus against a queue-level model
// of mem_req_queue; a negedge monitor compares the DUT with the model.
module tb_mem_req_queue;
    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 33;
    localparam int OP_W     = 2;
    localparam int TS_W     = 32;
    localparam int LIFE_MAX = 100;
    localparam int CNT_W    = $clog2(DEPTH + 1);
`ifdef MEM_REQ_QUEUE_AGE_EXPIRE_EN
    localparam bit EXP_EN = 1'b1;
`else
    localparam bit EXP_EN = 1'b0;
`endif

    logic             CPU_clock = 1'b0;
    logic             rst_n     = 1'b0;
    logic [TS_W-1:0]  cur_time;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             insert_flag;
    logic             expire_flag;

    mem_req_queue_if #(.ADDR_W(ADDR_W), .OP_W(OP_W), .TS_W(TS_W)) bus ();

    mem_req_queue #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OP_W(OP_W),
        .TS_W(TS_W), .LIFE_MAX(LIFE_MAX)
    ) dut (
        .CPU_clock  (CPU_clock),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .cur_time   (cur_time),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .insert_flag(insert_flag),
        .expire_flag(expire_flag)
    );

    always #5 CPU_clock = ~CPU_clock;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr;
        logic [TS_W-1:0]   t;
        longint            pe;
    } req_t;

    req_t            q[$];
    logic [TS_W-1:0] m_time = '0;
    bit              m_ins = 0;
    bit              m_exp = 0;
    bit              acc_last = 0;
    bit              started = 0;
    longint          edge_n = 0;
    int              checks = 0;
    int              errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, req, $time);
        end
    endtask

    // Reference: queue of pending requests tagged with their push edge.
    always @(posedge CPU_clock) begin : model
        int sz;
        bit emp, push, pop, exp_h, adv;
        sz = q.size();
        emp = (sz == 0);
        if (!rst_n) begin
            q.delete();
            m_time   = '0;
            m_ins    = 0;
            m_exp    = 0;
            acc_last = 0;
            started  = 1;
        end else begin
            push  = bus.in_valid && (sz < DEPTH) &&
                    ((bus.in_time <= m_time) || emp);
            adv   = emp && bus.in_valid && (bus.in_time > m_time);
            pop   = !emp && bus.out_ready;
            exp_h = EXP_EN && !emp && !bus.out_ready &&
                    ((edge_n - q[0].pe) >= LIFE_MAX);
            if (pop || exp_h) void'(q.pop_front());
            if (push) q.push_back('{bus.in_op, bus.in_addr, bus.in_time, edge_n});
            m_time   = adv ? bus.in_time : m_time + 1'b1;
            m_ins    = push;
            m_exp    = exp_h;
            acc_last = push;
        end
        edge_n++;
    end

    always @(negedge CPU_clock) begin : monitor
        if (started) begin
            chk("in_ready", 64'(bus.in_ready), 64'(rst_n && (q.size() < DEPTH)));
            chk("out_valid", 64'(bus.out_valid), 64'(rst_n && (q.size() > 0)));
            chk("count", 64'(count), 64'(q.size()));
            chk("full", 64'(full), 64'(q.size() == DEPTH));
            chk("empty", 64'(empty), 64'(q.size() == 0));
            chk("cur_time", 64'(cur_time), 64'(m_time));
            chk("insert_flag", 64'(insert_flag), 64'(m_ins));
            chk("expire_flag", 64'(expire_flag), 64'(m_exp));
            if (bus.out_valid && (q.size() > 0)) begin
                chk("out_op", 64'(bus.out_op), 64'(q[0].op));
                chk("out_addr", 64'(bus.out_addr), 64'(q[0].addr));
                chk("out_time", 64'(bus.out_time), 64'(q[0].t));
            end
        end
    end

    task automatic step();
        @(posedge CPU_clock);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic present(logic [TS_W-1:0] t, logic [ADDR_W-1:0] a);
        bus.in_valid = 1'b1;
        bus.in_time  = t;
        bus.in_addr  = a;
        bus.in_op    = OP_W'(a % 3);
    endtask

    initial begin : driver
        int n;
        logic [TS_W-1:0] t;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_op     = '0;
        bus.in_addr   = '0;
        bus.in_time   = '0;
        do_reset();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);

        // empty-queue time advance
        present(32'd500, 33'h1_2345_6789);
        step();
        bus.in_valid = 1'b0;
        chk("adv_time", 64'(cur_time), 64'd500);
        chk("adv_count", 64'(count), 64'd1);
        chk("adv_ins", 64'(insert_flag), 64'd1);
        chk("adv_addr", 64'(bus.out_addr), 64'h1_2345_6789);

        // timestamp gating: 15 waits until cur_time reaches 15
        do_reset();
        present(32'd10, 33'h10);
        step();
        present(32'd15, 33'h15);
        n = 0;
        do begin
            step();
            n++;
        end while (!insert_flag && n < 20);
        bus.in_valid = 1'b0;
        chk("gate_edges", 64'(n), 64'd6);
        chk("gate_time", 64'(cur_time), 64'd16);
        chk("gate_count", 64'(count), 64'd2);

        // fill to full, 17th held then accepted after one pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            present('0, ADDR_W'(i));
            step();
        end
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_ready", 64'(bus.in_ready), 64'd0);
        present('0, ADDR_W'(99));
        step();
        step();
        chk("held_count", 64'(count), 64'(DEPTH));
        chk("held_ins", 64'(insert_flag), 64'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("pop_ins", 64'(insert_flag), 64'd0);
        step();
        bus.in_valid = 1'b0;
        chk("late_ins", 64'(insert_flag), 64'd1);
        chk("late_count", 64'(count), 64'(DEPTH));

`ifdef MEM_REQ_QUEUE_AGE_EXPIRE_EN
        // expiry exactly LIFE_MAX edges after the push
        do_reset();
        present('0, 33'h77);
        step();
        bus.in_valid = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!expire_flag && n < 2 * LIFE_MAX);
        chk("exp_edges", 64'(n), 64'(LIFE_MAX));
        chk("exp_empty", 64'(empty), 64'd1);
        // same timing, but popped on that edge
        do_reset();
        present('0, 33'h78);
        step();
        bus.in_valid = 1'b0;
        for (int i = 1; i < LIFE_MAX; i++) step();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("pop_noexp", 64'(expire_flag), 64'd0);
        chk("pop_empty", 64'(empty), 64'd1);
`endif

        // reset mid-operation
        do_reset();
        for (int i = 0; i < 5; i++) begin
            present(TS_W'(i), ADDR_W'(200 + i));
            step();
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk("mid_count", 64'(count), 64'd0);
        chk("mid_time", 64'(cur_time), 64'd0);
        chk("mid_valid", 64'(bus.out_valid), 64'd0);
        rst_n = 1'b1;
        present(32'd500, 33'h0_0000_0abc);
        step();
        bus.in_valid = 1'b0;
        chk("re_time", 64'(cur_time), 64'd500);
        chk("re_addr", 64'(bus.out_addr), 64'h0_0000_0abc);

        // randomized traffic; a request stays presented until accepted
        for (int c = 0; c < 3000; c++) begin
            if (!bus.in_valid || acc_last) begin
                if ($urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 15) == 0) t = m_time + TS_W'(30);
                    else if (m_time < 3) t = m_time + TS_W'($urandom_range(0, 4));
                    else t = m_time + TS_W'($urandom_range(0, 6)) - TS_W'(3);
                    present(t, ADDR_W'({$urandom(), 1'b0}) ^ ADDR_W'(c));
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if ((c / 500) % 2 == 1) bus.out_ready = ($urandom_range(0, 7) == 0);
            else bus.out_ready = ($urandom_range(0, 1) == 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
